dir_queue_ctrl: RTL
===================

DIR_QUEUE_CTRL -- requirements
Module: dir_queue_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles required before a button level change is accepted (10 ms at 100 MHz).
REQ-002 Parameter RESET_DIR, default 2'b01, direction driven on dir after reset (Right).
REQ-003 CLK_100MHz  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; 0 forces reset state immediately.
REQ-005 Up, Right, Down, Left  input  1 each  raw asynchronous push-button levels, 1 = pressed.
REQ-006 tick  input  1  one-cycle game-update strobe, synchronous to CLK_100MHz (from UpdateClk domain logic).
REQ-007 dir  output  2  committed direction consumed by Snake: 00 Up, 01 Right, 10 Down, 11 Left.
REQ-008 pending_valid  output  1  1 while a direction is queued awaiting tick.
REQ-009 rejected  output  1  one-cycle pulse when a press is discarded as a reversal.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-011 Each synchronized button SHALL have its own debounce FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 RELEASED -> PRESS_WAIT on sync=1, counter cleared; PRESS_WAIT -> RELEASED if sync=0 before count completes.
REQ-013 PRESS_WAIT -> PRESSED when counter reaches DEBOUNCE_CYCLES-1 with sync still 1; a one-cycle press event SHALL be generated on that transition only.
REQ-014 PRESSED -> RELEASE_WAIT on sync=0; RELEASE_WAIT -> RELEASED after DEBOUNCE_CYCLES-1 stable-0 cycles, back to PRESSED if sync=1 earlier; no event on release.
REQ-015 Debounce counters SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits minimum and SHALL saturate, never wrap.
REQ-016 Holding a button SHALL produce exactly one press event; repeat requires full release.
REQ-017 Press events in the same cycle SHALL be resolved by fixed priority Up > Right > Down > Left; lower-priority events that cycle are dropped.
REQ-018 A winning event whose direction equals dir XOR 2'b10 SHALL be discarded and rejected pulsed the next cycle; pending state unchanged.
REQ-019 A winning event equal to dir SHALL be discarded silently (no queue, no rejected pulse).
REQ-020 Any other winning event SHALL load the one-deep pending register and set pending_valid next cycle, overwriting any earlier pending value (latest wins).
REQ-021 Queue FSM: EMPTY, FULL; EMPTY -> FULL on accepted event; FULL -> EMPTY on tick with no same-cycle accepted event.
REQ-022 On tick with pending_valid=1, dir SHALL take the pending value on the following edge and pending_valid SHALL clear.
REQ-023 On tick with pending_valid=0, dir SHALL hold.
REQ-024 Event and tick in the same cycle: tick commits the previously pending value; the new event is checked against the pre-commit dir and, if accepted, becomes pending (pending_valid stays 1).
REQ-025 dir SHALL change only on a tick cycle; latency from final debounce cycle to pending_valid = 1 cycle.

Reset
REQ-026 While Reset=0: dir=RESET_DIR, pending_valid=0, rejected=0, all debounce FSMs RELEASED, counters and synchronizers 0.
REQ-027 Reset asserted mid-debounce or with pending_valid=1 SHALL discard all in-flight state; a button held through reset release SHALL produce one press event after DEBOUNCE_CYCLES.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-028 Reset release, no input, 10 ticks -> dir=01, pending_valid=0, rejected never 1.
REQ-029 Up held 10 cycles, then tick -> pending_valid=1 after sync+4 cycles, dir=00 one cycle after tick, pending_valid=0.
REQ-030 From dir=01, Left pressed and debounced -> rejected pulses one cycle, pending_valid=0, dir stays 01 after tick.
REQ-031 Up glitch of 2 cycles, then Down held -> no Up event, pending=10 queued, dir=10 after tick; then Down+Left simultaneous new presses -> Down wins (equal to dir, silently dropped).
REQ-032 dir=01, pending=00, Down event coincides with tick -> dir=00, pending=10, pending_valid=1; next tick -> dir=10.
REQ-033 Reset pulsed low while pending_valid=1 and Right bouncing -> outputs return to 01/0/0 immediately, no stale commit on next tick.

Source files
------------

// File: rtl/dir_queue_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// dir_queue_ctrl : debounced direction buttons feeding a one-deep move queue
// Revision 1.0
// ============================================================================
module dir_queue_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter logic [1:0] RESET_DIR       = 2'b01
) (
  input  logic       CLK_100MHz,
  input  logic       Reset,
  input  logic       Up,
  input  logic       Right,
  input  logic       Down,
  input  logic       Left,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       pending_valid,
  output logic       rejected
);

  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_e;
  typedef enum logic       {EMPTY, FULL} q_state_e;

  // Bit index equals the direction code: Up=00, Right=01, Down=10, Left=11
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] press_evt;

  assign btn_raw = {Left, Down, Right, Up};

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_btn
    db_state_e        st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done;

    assign done = (cnt_q == CNT_MAX);

    // Counter only advances while not done, so it saturates at CNT_MAX
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      case (st_q)
        RELEASED: if (sync2_q[i]) begin
          st_d  = PRESS_WAIT;
          cnt_d = '0;
        end
        PRESS_WAIT: begin
          if (!sync2_q[i])  st_d  = RELEASED;
          else if (done)    st_d  = PRESSED;
          else              cnt_d = cnt_q + 1'b1;
        end
        PRESSED: if (!sync2_q[i]) begin
          st_d  = RELEASE_WAIT;
          cnt_d = '0;
        end
        RELEASE_WAIT: begin
          if (sync2_q[i])   st_d  = PRESSED;
          else if (done)    st_d  = RELEASED;
          else              cnt_d = cnt_q + 1'b1;
        end
        default: st_d = RELEASED;
      endcase
    end

    always_ff @(posedge CLK_100MHz or negedge Reset) begin
      if (!Reset) begin
        st_q  <= RELEASED;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    assign press_evt[i] = (st_q == PRESS_WAIT) && sync2_q[i] && done;
  end

  logic       evt_any, is_rev, is_same, accept;
  logic [1:0] win_dir;
  logic [1:0] dir_q, dir_d, pend_q, pend_d;
  logic       rejected_q, rejected_d;
  q_state_e   q_state_q, q_state_d;

  always_comb begin
    evt_any = |press_evt;
    if (press_evt[0])      win_dir = 2'b00;
    else if (press_evt[1]) win_dir = 2'b01;
    else if (press_evt[2]) win_dir = 2'b10;
    else                   win_dir = 2'b11;

    // Acceptance is judged against the pre-commit direction
    is_rev     = evt_any && (win_dir == (dir_q ^ 2'b10));
    is_same    = evt_any && (win_dir == dir_q);
    accept     = evt_any && !is_rev && !is_same;
    rejected_d = is_rev;

    dir_d = dir_q;
    if (tick && (q_state_q == FULL)) dir_d = pend_q;
    pend_d = accept ? win_dir : pend_q;

    q_state_d = q_state_q;
    case (q_state_q)
      EMPTY:   if (accept)          q_state_d = FULL;
      FULL:    if (tick && !accept) q_state_d = EMPTY;
      default: q_state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK_100MHz or negedge Reset) begin
    if (!Reset) begin
      dir_q      <= RESET_DIR;
      pend_q     <= RESET_DIR;
      q_state_q  <= EMPTY;
      rejected_q <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      pend_q     <= pend_d;
      q_state_q  <= q_state_d;
      rejected_q <= rejected_d;
    end
  end

  assign dir           = dir_q;
  assign pending_valid = (q_state_q == FULL);
  assign rejected      = rejected_q;

endmodule
`default_nettype wire
